hwpe_ctrl_uloop_issue: RTL

//  Drives the microloop engine from the controller side and turns its flag replies into a stream.
//  - Issues clear and enable pulses to the engine.
//  - Captures each flags reply (offsets, indices, loop, done).
//  - Forwards replies as a valid/ready stream of offset tuples to the streamer address generators.
//  - Decouples engine latency from streamer back-pressure through a small credit-managed FIFO.

---
 rtl/hwpe_ctrl_uloop_issue.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/hwpe_ctrl_uloop_issue.sv
// Controller-side driver for the microloop engine: issues clear/enable pulses,
// captures flag replies and forwards them as a credit-managed stream of offset tuples.
module hwpe_ctrl_uloop_issue #(
  parameter int unsigned NB_REG     = 4,
  parameter int unsigned REG_WIDTH  = 32,
  parameter int unsigned NB_LOOPS   = 6,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            test_mode_i,
  input  logic                            clear_i,
  input  logic                            start_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic [31:0]                     iter_cnt_o,
  output logic                            uloop_enable_o,
  output logic                            uloop_clear_o,
  input  logic                            uloop_ready_i,
  input  logic                            uloop_valid_i,
  input  logic                            uloop_done_i,
  input  logic [$clog2(NB_LOOPS)-1:0]     uloop_loop_i,
  input  logic [NB_REG*REG_WIDTH-1:0]     uloop_offs_i,
  input  logic [NB_LOOPS*CNT_WIDTH-1:0]   uloop_idx_i,
  output logic                            offs_valid_o,
  input  logic                            offs_ready_i,
  output logic [NB_REG*REG_WIDTH-1:0]     offs_data_o,
  output logic [NB_LOOPS*CNT_WIDTH-1:0]   offs_idx_o,
  output logic [$clog2(NB_LOOPS)-1:0]     offs_loop_o,
  output logic                            offs_last_o
);

  localparam int unsigned LW = $clog2(NB_LOOPS);
  localparam int unsigned OW = NB_REG * REG_WIDTH;
  localparam int unsigned IW = NB_LOOPS * CNT_WIDTH;
  localparam int unsigned EW = OW + IW + LW + 1;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLR   = 3'd1;
  localparam logic [2:0] REQ   = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]    r_state;
  logic [2:0]    w_state_next;
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_credits;
  logic          r_busy;
  logic [31:0]   r_iter_cnt;
  logic          w_push;
  logic          w_pop;
  logic          w_enable;
  logic          w_start;
  logic          w_empty_next;
  logic [EW-1:0] w_head;
  logic          w_unused;

  assign w_unused = test_mode_i;

  // Credits cover both stored tuples and in-flight requests, so a push always finds room.
  assign w_enable     = ~clear_i & (r_state == REQ) & (r_credits != '0) & uloop_ready_i;
  assign w_push       = ~clear_i & (r_state == WAIT) & uloop_valid_i;
  assign w_pop        = ~clear_i & offs_valid_o & offs_ready_i;
  assign w_start      = (r_state == IDLE) & start_i;
  assign w_empty_next = (r_count == '0) | ((r_count == CW'(1)) & w_pop);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start_i) w_state_next = CLR;
      CLR:     w_state_next = REQ;
      REQ:     if (w_enable) w_state_next = WAIT;
      WAIT:    if (uloop_valid_i) w_state_next = uloop_done_i ? DRAIN : REQ;
      DRAIN:   if (w_empty_next) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_credits  <= CW'(FIFO_DEPTH);
      r_busy     <= 1'b0;
      r_iter_cnt <= '0;
    end else if (clear_i) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_credits  <= CW'(FIFO_DEPTH);
      r_busy     <= 1'b0;
      r_iter_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      case ({w_enable, w_pop})
        2'b10:   r_credits <= r_credits - CW'(1);
        2'b01:   r_credits <= r_credits + CW'(1);
        default: r_credits <= r_credits;
      endcase
      if (w_start) begin
        r_iter_cnt <= '0;
      end else if (w_pop) begin
        r_iter_cnt <= r_iter_cnt + 32'd1;
      end
      if (w_start) begin
        r_busy <= 1'b1;
      end else if (r_state == DONE) begin
        r_busy <= 1'b0;
      end
    end
  end

  // Storage needs no reset: an entry is only observable once written and counted.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= {uloop_offs_i, uloop_idx_i, uloop_loop_i, uloop_done_i};
  end

  assign w_head = offs_valid_o ? r_mem[r_rd_ptr] : '0;

  assign offs_valid_o   = (r_count != '0);
  assign offs_data_o    = w_head[EW-1 -: OW];
  assign offs_idx_o     = w_head[LW+1 +: IW];
  assign offs_loop_o    = w_head[1 +: LW];
  assign offs_last_o    = w_head[0];
  assign uloop_enable_o = w_enable;
  assign uloop_clear_o  = clear_i | (r_state == CLR);
  assign done_o         = (r_state == DONE);
  assign busy_o         = r_busy;
  assign iter_cnt_o     = r_iter_cnt;

endmodule
